fp_sqrt_sequencer: RTL
======================

Name: fp_sqrt_sequencer

Overview:
- Compact sequencer for the FP square-root datapath. It replaces the flat per-state controller with a phase FSM plus an iteration counter.
- Accepts a start request and runs INIT0, INIT1, then NUM_ITER Newton iterations of phases A-B-C-D (the last iteration omits D), then OUT.
- Drives the 14-bit datapath control word and a done/busy handshake.
- Sits between the top-level FP_SQRT wrapper and the datapath register/mux enables.

Parameters:
- NUM_ITER, 11, number of Newton iterations; legal range 1..15.
- ITER_W, 4, iteration counter width; must hold NUM_ITER.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start_i  input  1  start request; sampled only in IDLE.
- Special_i  input  1  operand is a special case (zero/NaN/Inf/negative); sampled together with Start_i.
- Ctrl_o  output  14  datapath control word.
- Busy_o  output  1  high in every state except IDLE.
- Done_o  output  1  one-cycle pulse; the result register is valid.
- Iter_o  output  ITER_W  current iteration number (debug/visibility).

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high (Rst); the polarity and synchronicity are fixed.
- Reset:
  - state=IDLE, iteration counter=0.
  - Ctrl_o=14'b0, Busy_o=0, Done_o=0, Iter_o=0.
  - Rst asserted mid-run aborts immediately to IDLE; there is no partial Done.
- Moore machine: Ctrl_o, Busy_o and Done_o are decoded only from the registered state. Iter_o is the counter register.
- States and Ctrl_o:
  - IDLE 00000000000000
  - INIT0 11001000000000
  - INIT1 01010001000000
  - ITER_A 01011001010100
  - ITER_B 01011011010000
  - ITER_C 01011011101100
  - ITER_D 01010011000000
  - OUT 00111011000001
- Transitions:
  - IDLE: Start_i=1 and Special_i=0 -> INIT0. Start_i=1 and Special_i=1 -> OUT (bypass). Otherwise stay.
  - INIT0 -> INIT1.
  - INIT1 -> ITER_A; counter loads 1.
  - ITER_A -> ITER_B -> ITER_C.
  - ITER_C: counter==NUM_ITER -> OUT; else -> ITER_D.
  - ITER_D -> ITER_A; counter increments.
  - OUT -> IDLE unconditionally; counter clears to 0.
- Done_o=1 only in OUT, so it is exactly one cycle wide.
- Start_i is ignored whenever Busy_o=1, including in OUT. No queuing: a request must be re-presented in IDLE.
- Start_i held high continuously restarts a new run on the cycle after OUT, because IDLE is visited for one cycle.
- Latency: with Start_i sampled at edge 0 (normal path), OUT is entered at edge 4*NUM_ITER+1, which is edge 45 for the default. Special bypass: OUT is entered at edge 0.
- Iteration state count = 4*NUM_ITER-1 (43 for the default). Total non-IDLE cycles = 4*NUM_ITER+2 (46 for the default).
- Counter never exceeds NUM_ITER and does not wrap.
- Illegal or unused state encodings -> IDLE on the next edge, with Ctrl_o=0 while there.

Decomposition:
- Package fp_sqrt_pkg holds:
  - the state encoding enum/localparams: IDLE, INIT0, INIT1, ITER_A..D, OUT;
  - the eight 14-bit control-word constants;
  - the CTRL_W=14 constant.
- One natural sub-module, fp_sqrt_ctrl_decode: the combinational state -> Ctrl_o/Busy_o/Done_o decoder.
- The top holds the state register, next-state logic and iteration counter.

Test Plan:
1. Reset mid-run: assert Rst during ITER_B of iteration 3 -> next observation shows IDLE, Ctrl_o=0, Busy_o=0, Iter_o=0. Then Start_i=1 -> normal run completes with Done at +45.
2. Normal run, NUM_ITER=11, Start_i pulse at edge 0, Special_i=0:
   - Ctrl_o sequence is INIT0, INIT1, then {A,B,C,D}x10, then A,B,C, then OUT.
   - Done_o=1 only in the cycle after edge 45.
   - Busy_o high for exactly 46 cycles.
   - Iter_o steps 1..11.
3. Special bypass: Start_i=1 with Special_i=1 -> next cycle Ctrl_o=00111011000001, Done_o=1, Busy_o=1; the following cycle is IDLE with Ctrl_o=0.
4. Start while busy: pulse Start_i in ITER_C of iteration 5 and again during OUT -> no restart; Done_o pulses once; Iter_o unaffected.
5. Back-to-back: Start_i held high for 100 cycles -> two Done pulses 47 cycles apart, with one IDLE cycle between runs.
6. Parameter edge, NUM_ITER=1: Start at edge 0 -> sequence INIT0, INIT1, A, B, C, OUT; Done after edge 5; ITER_D never visited.

Source files
------------

// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg
//   Shared definitions for the FP square-root sequencer: the phase-state
//   encoding, the datapath control-word width and the control word that
//   each state drives onto the datapath register/mux enables.
package fp_sqrt_pkg;

  localparam int CTRL_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT0  = 3'd1,
    ST_INIT1  = 3'd2,
    ST_ITER_A = 3'd3,
    ST_ITER_B = 3'd4,
    ST_ITER_C = 3'd5,
    ST_ITER_D = 3'd6,
    ST_OUT    = 3'd7
  } state_t;

  localparam logic [CTRL_W-1:0] CTRL_IDLE   = 14'b00000000000000;
  localparam logic [CTRL_W-1:0] CTRL_INIT0  = 14'b11001000000000;
  localparam logic [CTRL_W-1:0] CTRL_INIT1  = 14'b01010001000000;
  localparam logic [CTRL_W-1:0] CTRL_ITER_A = 14'b01011001010100;
  localparam logic [CTRL_W-1:0] CTRL_ITER_B = 14'b01011011010000;
  localparam logic [CTRL_W-1:0] CTRL_ITER_C = 14'b01011011101100;
  localparam logic [CTRL_W-1:0] CTRL_ITER_D = 14'b01010011000000;
  localparam logic [CTRL_W-1:0] CTRL_OUT    = 14'b00111011000001;

endpackage

// File: rtl/fp_sqrt_ctrl_decode.sv
// fp_sqrt_ctrl_decode
//   Pure combinational Moore decode of the registered sequencer state.
//   Ports:
//     state  in   current (registered) sequencer state
//     ctrl   out  CTRL_W-bit datapath control word
//     busy   out  high in every state except IDLE
//     done   out  high only in OUT (result register valid)
module fp_sqrt_ctrl_decode
  import fp_sqrt_pkg::*;
(
  input  state_t            state,
  output logic [CTRL_W-1:0] ctrl,
  output logic              busy,
  output logic              done
);

  always_comb begin
    ctrl = CTRL_IDLE;
    busy = 1'b1;
    done = 1'b0;
    case (state)
      ST_IDLE: begin
        ctrl = CTRL_IDLE;
        busy = 1'b0;
      end
      ST_INIT0:  ctrl = CTRL_INIT0;
      ST_INIT1:  ctrl = CTRL_INIT1;
      ST_ITER_A: ctrl = CTRL_ITER_A;
      ST_ITER_B: ctrl = CTRL_ITER_B;
      ST_ITER_C: ctrl = CTRL_ITER_C;
      ST_ITER_D: ctrl = CTRL_ITER_D;
      ST_OUT: begin
        ctrl = CTRL_OUT;
        done = 1'b1;
      end
      // Any encoding outside the enum is treated as a quiet IDLE.
      default: begin
        ctrl = CTRL_IDLE;
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fp_sqrt_sequencer.sv
// fp_sqrt_sequencer
//   Phase FSM plus iteration counter that sequences the FP square-root
//   datapath: INIT0, INIT1, then NUM_ITER Newton iterations of A-B-C-D
//   (the last iteration skips D), then OUT. Special operands bypass
//   straight to OUT.
//   Parameters:
//     NUM_ITER  number of Newton iterations (1..15)
//     ITER_W    iteration counter width, must hold NUM_ITER
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   asynchronous active-high reset
//     start    in   start request, sampled only in IDLE
//     special  in   special-case operand, sampled with start
//     ctrl     out  datapath control word
//     busy     out  high in every state except IDLE
//     done     out  one-cycle result-valid pulse
//     iter     out  current iteration number
module fp_sqrt_sequencer
  import fp_sqrt_pkg::*;
#(
  parameter int NUM_ITER = 11,
  parameter int ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              special,
  output logic [CTRL_W-1:0] ctrl,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER);

  state_t            state_reg;
  logic [ITER_W-1:0] iter_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      iter_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          iter_reg <= '0;
          if (start) begin
            state_reg <= special ? ST_OUT : ST_INIT0;
          end
        end
        ST_INIT0: state_reg <= ST_INIT1;
        ST_INIT1: begin
          state_reg <= ST_ITER_A;
          iter_reg  <= ITER_W'(1);
        end
        ST_ITER_A: state_reg <= ST_ITER_B;
        ST_ITER_B: state_reg <= ST_ITER_C;
        ST_ITER_C: begin
          // The final iteration leaves from C; D only bridges to the next one.
          if (iter_reg == LAST_ITER) begin
            state_reg <= ST_OUT;
          end else begin
            state_reg <= ST_ITER_D;
          end
        end
        ST_ITER_D: begin
          state_reg <= ST_ITER_A;
          // Saturate so the counter can never run past the last iteration.
          if (iter_reg < LAST_ITER) begin
            iter_reg <= iter_reg + ITER_W'(1);
          end
        end
        ST_OUT: begin
          state_reg <= ST_IDLE;
          iter_reg  <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
          iter_reg  <= '0;
        end
      endcase
    end
  end

  fp_sqrt_ctrl_decode u_decode (
    .state (state_reg),
    .ctrl  (ctrl),
    .busy  (busy),
    .done  (done)
  );

  assign iter = iter_reg;

endmodule
